// File: rtl/sume_sched.sv
// sume_sched: round-robin scheduler sharing one sample-summing datapath
// between two producers. One burst of LEN samples per grant, and the sum
// is published with the requester ID as a one-cycle pulse.
module sume_sched #(
    parameter int unsigned W   = 4,
    parameter int unsigned LEN = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   req,
    input  logic [W-1:0]                 sample0,
    input  logic                         valid0,
    output logic                         ready0,
    input  logic [W-1:0]                 sample1,
    input  logic                         valid1,
    output logic                         ready1,
    output logic [1:0]                   gnt,
    output logic [W+$clog2(LEN)-1:0]     sum,
    output logic                         sum_valid,
    output logic                         sum_id,
    output logic                         busy
);

    localparam int unsigned CNT_W = $clog2(LEN);
    localparam int unsigned ACC_W = W + CNT_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             last_id;
    logic             cur_id;

    logic             pick_id;
    logic             sel_valid;
    logic [W-1:0]     sel_sample;
    logic             accept;
    logic             last_beat;

    // Arbitration: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        pick_id = 1'b0;
        case (req)
            2'b10:   pick_id = 1'b1;
            2'b11:   pick_id = ~last_id;
            default: pick_id = 1'b0;
        endcase
    end

    // Steer the granted requester's handshake into the datapath.
    always_comb begin
        sel_valid  = cur_id ? valid1  : valid0;
        sel_sample = cur_id ? sample1 : sample0;
        accept     = (state == S_ACC) && sel_valid;
        last_beat  = (cnt == CNT_W'(LEN - 1));
    end

    // Ready follows the registered grant only, so it never depends on valid.
    assign ready0 = gnt[0];
    assign ready1 = gnt[1];
    assign busy   = (state != S_IDLE);

    // Scheduler FSM with grant, accumulator and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            gnt       <= 2'b00;
            acc       <= '0;
            cnt       <= '0;
            last_id   <= 1'b1;
            cur_id    <= 1'b0;
            sum       <= '0;
            sum_valid <= 1'b0;
            sum_id    <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        state  <= S_ACC;
                        cur_id <= pick_id;
                        gnt    <= pick_id ? 2'b10 : 2'b01;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                S_ACC: begin
                    if (accept) begin
                        acc <= acc + ACC_W'(sel_sample);
                        cnt <= cnt + CNT_W'(1);
                        if (last_beat) begin
                            state <= S_DONE;
                            gnt   <= 2'b00;
                        end
                    end
                end
                S_DONE: begin
                    sum       <= acc;
                    sum_valid <= 1'b1;
                    sum_id    <= cur_id;
                    last_id   <= cur_id;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    gnt   <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: doc/sume_sched.md
# sume_sched

Round-robin scheduler that shares the 4-bit sample-summing datapath between two sample producers. It grants one requester at a time, accepts a burst of exactly `LEN` samples from the granted requester over a valid/ready handshake, and accumulates them. It then publishes the burst sum with the requester ID as a one-cycle result pulse. It sits between the sample sources and the downstream `w`-side consumer.

## Interface
- `W`, 4, sample width in bits
- `LEN`, 4, samples per burst (≥2)
- `ACC_W` (derived, not overridable) = `W + $clog2(LEN)`, sum width; sized so `LEN*(2^W-1)` never overflows
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req`  in  2  per-requester burst request; bit i = requester i
- `sample0`  in  W  requester 0 sample data
- `valid0`  in  1  `sample0` valid
- `ready0`  out  1  scheduler accepts `sample0` this cycle
- `sample1`  in  W  requester 1 sample data
- `valid1`  in  1  `sample1` valid
- `ready1`  out  1  scheduler accepts `sample1` this cycle
- `gnt`  out  2  one-hot grant, registered; `00` when idle
- `sum`  out  ACC_W  last completed burst sum, held until the next completion
- `sum_valid`  out  1  one-cycle pulse marking a new `sum`
- `sum_id`  out  1  requester that produced `sum`
- `busy`  out  1  high in ACC and DONE

## Operation
- States: IDLE, ACC, DONE. Internal registers: `acc` (ACC_W), `cnt` (`$clog2(LEN)`), `last_id` (1 bit).
- IDLE:
  - `req` is sampled only here.
  - If `req != 0`, go to ACC. Set `gnt`, clear `acc` and `cnt`.
  - Winner selection:
    - Only one bit set: that requester wins.
    - Both bits set: requester `~last_id` wins.
  - `req == 0`: stay in IDLE.
- ACC:
  - `ready_i = gnt[i]`. Ready depends on registered state only, never on `valid`.
  - Acceptance = `valid_i & ready_i` of the granted requester.
  - On acceptance: `acc <= acc + zero-extended sample_i` and `cnt <= cnt + 1`.
  - Acceptance with `cnt == LEN-1` goes to DONE.
  - Cycles without acceptance (valid low) hold all state. There is no timeout.
- DONE (exactly one cycle):
  - `sum <= acc`, `sum_valid = 1`, `sum_id` = granted index, `last_id` = granted index.
  - `gnt <= 00`, ready low.
  - Next state is IDLE.
- Non-granted requester: ready stays 0, and its valid/sample are ignored. A requester may hold valid indefinitely.
- Deasserting `req` mid-burst has no effect. The burst still completes after LEN acceptances.
- Arithmetic is unsigned. Samples are zero-extended to ACC_W. Overflow is impossible by construction.
- Reset (any time, including mid-burst):
  - State returns to IDLE and the partial sum is discarded.
  - `last_id = 1`, so requester 0 wins the first contended arbitration.
  - Output reset values: `gnt=00`, `ready0=ready1=0`, `sum=0`, `sum_valid=0`, `sum_id=0`, `busy=0`.

## Timing
- `req` seen high in IDLE at edge N: `gnt` and `ready` are high from N (after the edge) through the LEN-th acceptance edge.
- Last acceptance at edge M: `sum`, `sum_id` and `sum_valid` update at M+1. `sum_valid` is high for cycle M+1 only.
- IDLE at M+2. If `req` is still asserted, the next `gnt` is registered at edge M+2.
- Best-case throughput: LEN+2 cycles per burst (LEN accept, DONE, IDLE).
- `gnt` is never `11`. It is never nonzero in IDLE or DONE.
- `sum` is stable between `sum_valid` pulses.
- `busy` is combinational from state.

## Test plan
- Reset: hold `reset=0` with random inputs. Check every output equals its reset value, and that `ready0`/`ready1` stay 0 while `valid` is high.
- Single burst: `req=01`, sample0 = 1,2,3,4 with valid every cycle. Expect `gnt=01` for 4 cycles, then `sum=10`, `sum_id=0`, `sum_valid` high for 1 cycle, then `gnt=00`.
- Contention and fairness: `req=11` held for 3 bursts with all samples = 5. Expect grant order 0,1,0, each `sum=20`, `sum_id` sequence 0,1,0, and LEN+2 cycles between `sum_valid` pulses.
- Max values with handshake gaps: requester 1 sends four samples of 15 with valid low on alternate cycles. Expect `sum=60` (6'b111100) and `cnt` unchanged on gap cycles.
- Requester drops `req` mid-burst: `req0` falls after 2 acceptances. Expect the burst to continue to 4 acceptances and `sum_valid` to assert once.
- Reset mid-burst: assert `reset` after 2 accepted samples (7,7). Expect immediate return to the reset values. After release, a fresh burst 1,1,1,1 yields `sum=4`, with no residue from the discarded partial sum of 14.
